// File: rtl/sram_rw_port_initiator.sv
// Ready/valid front end for a single-ported RW0 SRAM macro. Hides the one-cycle
// read latency behind a small in-order response queue with a bypass path.
module sram_rw_port_initiator #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = (DEPTH > 3) ? 3 : 2;

  logic              inflight;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W-1:0]  occupancy;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DATA_W-1:0] q_mem [DEPTH];

  logic fire;
  logic q_nonempty;
  logic bypass;
  logic enq;
  logic deq;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads in flight count against capacity so the captured rdata always has a slot.
  assign occupancy = q_count + CNT_W'(inflight);
  assign req_ready = !reset && (occupancy < CNT_W'(DEPTH));
  assign fire      = req_valid && req_ready;

  assign RW0_en    = fire;
  assign RW0_wmode = fire && req_write;
  assign RW0_addr  = req_addr;
  assign RW0_wmask = req_wmask;
  assign RW0_wdata = req_wdata;

  assign q_nonempty = (q_count != '0);
  assign resp_valid = !reset && (q_nonempty || inflight);
  assign resp_rdata = q_nonempty ? q_mem[head] : RW0_rdata;

  assign bypass = inflight && !q_nonempty && resp_ready;
  assign enq    = inflight && !bypass;
  assign deq    = q_nonempty && resp_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= 1'b0;
      q_count  <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= fire && !req_write;
      if (enq) tail <= wrap_inc(tail);
      if (deq) head <= wrap_inc(head);
      case ({enq, deq})
        2'b10:   q_count <= q_count + CNT_W'(1);
        2'b01:   q_count <= q_count - CNT_W'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (enq) q_mem[tail] <= RW0_rdata;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(enq && !deq && (q_count == CNT_W'(DEPTH))));
  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    q_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_sram_rw_port_initiator.sv
// Bench for sram_rw_port_initiator: behavioural SRAM plus a reference memory and
// an expected-response queue; directed scenarios followed by random traffic.
module tb_sram_rw_port_initiator;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int DEPTH  = 2;
  localparam int G      = DATA_W / MASK_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [DATA_W-1:0] sram    [1 << ADDR_W];
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  logic [DATA_W-1:0] expq[$];

  always #5 clock = ~clock;

  sram_rw_port_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  // SRAM macro: rdata is junk except in the cycle following a read.
  always @(posedge clock) begin
    if (RW0_en && RW0_wmode) begin
      for (int i = 0; i < MASK_W; i++)
        if (RW0_wmask[i]) sram[RW0_addr][i*G +: G] <= RW0_wdata[i*G +: G];
    end
    if (RW0_en && !RW0_wmode) RW0_rdata <= sram[RW0_addr];
    else                      RW0_rdata <= {$urandom, $urandom};
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < MASK_W; i++)
      if (m[i]) r[i*G +: G] = d[i*G +: G];
    return r;
  endfunction

  // Inputs are already driven; sample outputs mid-cycle, update the model, move on.
  task automatic tick(output logic fired);
    logic [DATA_W-1:0] e;
    fired = 1'b0;
    #1;
    if (reset) begin
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_resp_valid", 64'(resp_valid), 64'(0));
      check("rst_en", 64'(RW0_en), 64'(0));
      expq.delete();
    end else begin
      check("req_ready", 64'(req_ready), 64'(expq.size() < DEPTH));
      check("resp_valid", 64'(resp_valid), 64'(expq.size() > 0));
      if (resp_valid && resp_ready && expq.size() > 0) begin
        e = expq.pop_front();
        check("rdata", resp_rdata, e);
      end
      if (req_valid && req_ready) begin
        fired = 1'b1;
        check("en", 64'(RW0_en), 64'(1));
        check("wmode", 64'(RW0_wmode), 64'(req_write));
        if (req_write) ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
        else           expq.push_back(ref_mem[req_addr]);
      end else begin
        check("idle_wmode", 64'(RW0_wmode), 64'(0));
      end
    end
    @(negedge clock);
  endtask

  task automatic do_req(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    logic f;
    f = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    for (int n = 0; n < 40 && !f; n++) tick(f);
    if (!f) check("req_accept_timeout", 64'(0), 64'(1));
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic f;
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(f);
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    for (int n = 0; n < 20 && expq.size() > 0; n++) idle(1);
    check("drain_empty", 64'(expq.size()), 64'(0));
    idle(1);
  endtask

  initial begin
    logic f;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;
    @(negedge clock);
    tick(f); tick(f);
    reset = 1'b0;
    idle(1);

    // full write, read back with latency 1
    do_req(1'b1, 9'h005, 64'h1122334455667788, 8'hFF);
    do_req(1'b0, 9'h005, '0, '0);
    idle(2);
    // partial write over low lanes
    do_req(1'b1, 9'h005, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_req(1'b0, 9'h005, '0, '0);
    idle(2);
    check("partial_ref", ref_mem[5], 64'h11223344AAAAAAAA);

    // preload 0..7 then 8 back-to-back reads
    for (int i = 0; i < 8; i++) do_req(1'b1, ADDR_W'(i), 64'(i), 8'hFF);
    req_valid = 1'b1; req_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = ADDR_W'(i);
      tick(f);
      check("b2b_fire", 64'(f), 64'(1));
    end
    req_valid = 1'b0;
    idle(2);

    // backpressure: only DEPTH reads accepted
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr = ADDR_W'(i);
      tick(f);
      check("bp_fire", 64'(f), 64'(i < DEPTH));
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    drain();

    // write-after-read hazard to 0x010
    do_req(1'b1, 9'h010, 64'h55, 8'hFF);
    idle(1);
    resp_ready = 1'b0;
    do_req(1'b0, 9'h010, '0, '0);
    do_req(1'b1, 9'h010, 64'h99, 8'hFF);
    check("hazard_head", expq[0], 64'h55);
    drain();
    do_req(1'b0, 9'h010, '0, '0);
    idle(2);

    // reset with one queued and one inflight read
    resp_ready = 1'b0;
    do_req(1'b0, 9'h001, '0, '0);
    do_req(1'b0, 9'h002, '0, '0);
    reset = 1'b1;
    tick(f);
    reset = 1'b0;
    resp_ready = 1'b1;
    idle(3);

    // random traffic on a narrow address window to provoke hazards
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 149) == 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_write  = ($urandom_range(0, 2) == 0);
      req_addr   = ADDR_W'($urandom_range(0, 15));
      req_wdata  = {$urandom, $urandom};
      req_wmask  = MASK_W'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      tick(f);
    end
    reset = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
